// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm -- multi-cycle CPU control state machine.
//
// Sequences IF -> ID -> EX -> MEM -> WB for a small MIPS-like instruction
// set (R, ADDI, LW, SW, BEQ, J, HALT; anything else behaves as a NOP).
// Both memory ports use a req/ack handshake: req is held until ack, and
// the control outputs that depend on ack are combinational in that cycle.
//
// Optional build macro:
//   CTRL_STALL_CNT_EN  -- when defined, stall_cnt counts handshake wait
//                         cycles (saturating). When undefined it is tied to 0.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   opcode     in   6-bit opcode from IR, sampled in ID
//   zero       in   ALU zero flag, used in EX for BEQ
//   imem_req   out  instruction fetch request      / imem_ack in
//   dmem_req   out  data memory request, dmem_we   / dmem_ack in
//   pc_we      out  PC write enable; pc_src 00=PC+4 01=branch 10=jump
//   ir_we      out  instruction register write enable
//   reg_we     out  register file write; reg_dst 1=rd; mem_to_reg 1=load data
//   alu_src    out  1 = immediate operand; alu_op 000=ADD 001=SUB 111=funct
//   halted     out  high in HALT
//   stall_cnt  out  16-bit saturating wait-cycle counter
module cpu_ctrl_fsm (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] op_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ID) op_q <= opcode;
    end
  end

  // ID decodes the live opcode (op_q is being loaded on this same edge);
  // every later state decodes op_q.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    halted     = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_IF;
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          pc_src    = 2'b00;
          state_nxt = ST_ID;
        end
      end
      ST_ID: begin
        case (opcode)
          OP_J: begin
            pc_we     = 1'b1;
            pc_src    = 2'b10;
            state_nxt = ST_IF;
          end
          OP_HALT:                            state_nxt = ST_HALT;
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_nxt = ST_EX;
          default:                            state_nxt = ST_IF;
        endcase
      end
      ST_EX: begin
        case (op_q)
          OP_R: begin
            alu_op    = 3'b111;
            state_nxt = ST_WB;
          end
          OP_ADDI: begin
            alu_src   = 1'b1;
            state_nxt = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_src   = 1'b1;
            state_nxt = ST_MEM;
          end
          OP_BEQ: begin
            alu_op    = 3'b001;
            pc_src    = 2'b01;
            pc_we     = zero;
            state_nxt = ST_IF;
          end
          default: state_nxt = ST_IF;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
        if (dmem_ack) state_nxt = (op_q == OP_LW) ? ST_WB : ST_IF;
      end
      ST_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        state_nxt  = ST_IF;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CTRL_STALL_CNT_EN
  logic stall;
  assign stall = (imem_req & ~imem_ack) | (dmem_req & ~dmem_ack);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
